// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit path. Takes a parallel word over a valid/ready handshake and
//   shifts it out on a registered, idle-high serial line: one start bit,
//   DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop
//   bits. Every bit is held for CLKS_PER_BIT cycles of clk.
//
// Ports
//   clk       in   system / oversample clock, all logic on posedge
//   rst       in   synchronous active-high reset; aborts any frame in flight
//   tx_data   in   word to send, sampled only on the accept cycle
//   tx_valid  in   tx_data is valid
//   tx_ready  out  high only while idle; accept = tx_valid & tx_ready
//   txbit     out  serial line (registered)
//   tx_busy   out  high while a frame is in progress
//   tx_done   out  one-cycle pulse on the edge the frame completes
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txbit,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [7:0] CYC_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  state_t                 state_reg, state_next;
  logic [7:0]             cyc_reg, cyc_next;
  logic [3:0]             bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   parity_reg, parity_next;
  logic                   txbit_reg, txbit_next;
  logic                   done_reg, done_next;

  logic                   accept;
  logic                   bit_end;

  // Parity of the incoming word, seeded with the odd/even selection so the
  // chain output is directly the bit to transmit.
  logic [DATA_BITS:0]     par_chain;

  assign par_chain[0] = (PARITY_ODD != 0);

  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ tx_data[gi];
    end
  endgenerate

  assign accept  = tx_valid && (state_reg == S_IDLE);
  assign bit_end = (cyc_reg == CYC_LAST);

  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    done_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cyc_next = 8'd0;
        bit_next = 4'd0;
        if (accept) begin
          shift_next  = tx_data;
          parity_next = par_chain[DATA_BITS];
          state_next  = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          cyc_next   = 8'd0;
          bit_next   = 4'd0;
          state_next = S_DATA;
        end else begin
          cyc_next = cyc_reg + 8'd1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cyc_next   = 8'd0;
          shift_next = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next   = 4'd0;
            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end else begin
          cyc_next = cyc_reg + 8'd1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          cyc_next   = 8'd0;
          bit_next   = 4'd0;
          state_next = S_STOP;
        end else begin
          cyc_next = cyc_reg + 8'd1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cyc_next = 8'd0;
          if (bit_reg == STOP_LAST) begin
            bit_next   = 4'd0;
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end else begin
          cyc_next = cyc_reg + 8'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
        cyc_next   = 8'd0;
        bit_next   = 4'd0;
      end
    endcase

    // txbit is registered, so it is decoded from the state being entered:
    // the line changes on the same edge as the state.
    case (state_next)
      S_START:  txbit_next = 1'b0;
      S_DATA:   txbit_next = shift_next[0];
      S_PARITY: txbit_next = parity_next;
      default:  txbit_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cyc_reg    <= 8'd0;
      bit_reg    <= 4'd0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      txbit_reg  <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      txbit_reg  <= txbit_next;
      done_reg   <= done_next;
    end
  end

  assign tx_ready = (state_reg == S_IDLE);
  assign tx_busy  = (state_reg != S_IDLE);
  assign txbit    = txbit_reg;
  assign tx_done  = done_reg;

endmodule
